// File: rtl/conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer
//
// Walks a (2*QUAD_DIM) x (2*QUAD_DIM) feature map as four QUAD_DIM x QUAD_DIM
// quadrants (TL, TR, BL, BR). Inside each quadrant it visits every KERNEL x
// KERNEL window at stride 1. For each window it streams every kernel tap to
// the stage-1 MAC datapath as absolute (row, col) pixel coordinates, using a
// valid/ready handshake.
//
// The loops are nested as follows, with k_col the innermost and quadrant the
// outermost: k_col, k_row, win_col, win_row, quadrant. It also produces the
// step strobes for the column index counter that sits in the same stage.
//
// Ports
//   clock         system clock, rising edge
//   clear         synchronous active-high reset; beats start and every transition
//   start         begin one full-map pass (only looked at while idle)
//   ready         datapath accepts the current beat
//   busy          high from LOAD through DONE inclusive
//   done          one-cycle pulse when the pass completes
//   pixel_valid   pixel_row / pixel_col carry a beat
//   pixel_row     absolute row    = quadrant[1]*QUAD_DIM + win_row + k_row
//   pixel_col     absolute column = quadrant[0]*QUAD_DIM + win_col + k_col
//   quadrant      00 TL, 01 TR, 10 BL, 11 BR
//   quadrant_lsb  copy of quadrant[0]
//   en            pixel_valid & ready (one beat accepted)
//   new_row       accepted beat that closes a kernel row
//   new_vector    accepted beat that closes a window
//   clear_count   column counter reload (LOAD, and the last beat of quadrants 0..2)
//   stall_cycles  (optional) saturating count of cycles with pixel_valid & ~ready
//
// Optional feature macro: CONV_SEQ_STALL_COUNT_EN
//   When this macro is defined, the stall_cycles port and its counter exist.
//   When it is undefined, neither exists. All other behaviour is the same.
// ---------------------------------------------------------------------------
module conv_window_sequencer #(
   parameter int unsigned QUAD_DIM = 6,
   parameter int unsigned KERNEL   = 3
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       start,
   input  logic       ready,
   output logic       busy,
   output logic       done,
   output logic       pixel_valid,
   output logic [3:0] pixel_row,
   output logic [3:0] pixel_col,
   output logic [1:0] quadrant,
   output logic       quadrant_lsb,
   output logic       en,
   output logic       new_row,
   output logic       new_vector,
   output logic       clear_count
`ifdef CONV_SEQ_STALL_COUNT_EN
   ,
   output logic [15:0] stall_cycles
`endif
);

   // Last value of each index. Coordinates are 4 bits wide, so every
   // dimension fits in 4 bits.
   localparam logic [3:0] K_LAST = 4'(KERNEL - 1);
   localparam logic [3:0] W_LAST = 4'(QUAD_DIM - KERNEL);
   localparam logic [3:0] Q_DIM  = 4'(QUAD_DIM);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0] state_reg, state_next;

   logic [3:0] k_col_reg,   k_col_next;
   logic [3:0] k_row_reg,   k_row_next;
   logic [3:0] win_col_reg, win_col_next;
   logic [3:0] win_row_reg, win_row_next;
   logic [1:0] quad_reg,    quad_next;

   logic       busy_reg,  busy_next;
   logic       done_reg,  done_next;
   logic       valid_reg, valid_next;
   logic [3:0] row_reg,   row_next;
   logic [3:0] col_reg,   col_next;

   logic       handshake;
   logic       k_col_last, k_row_last, win_col_last, win_row_last;
   logic       window_last;
   logic       quad_last_beat;
   logic       pass_last_beat;

   // ------------------------------------------------------------------
   // Wrap detection on the registered indices. These flags describe the
   // beat that is being presented in this cycle.
   // ------------------------------------------------------------------
   assign handshake      = valid_reg & ready;
   assign k_col_last     = (k_col_reg   == K_LAST);
   assign k_row_last     = (k_row_reg   == K_LAST);
   assign win_col_last   = (win_col_reg == W_LAST);
   assign win_row_last   = (win_row_reg == W_LAST);
   assign window_last    = k_col_last & k_row_last;
   assign quad_last_beat = window_last & win_col_last & win_row_last;
   assign pass_last_beat = quad_last_beat & (quad_reg == 2'b11);

   // ------------------------------------------------------------------
   // Index chain. Only an accepted beat moves the indices. Each wrap
   // carries into the next index out. After the last beat of the pass,
   // every index wraps back to zero, so the next pass starts clean
   // without extra initialisation.
   // ------------------------------------------------------------------
   always_comb begin
      k_col_next   = k_col_reg;
      k_row_next   = k_row_reg;
      win_col_next = win_col_reg;
      win_row_next = win_row_reg;
      quad_next    = quad_reg;
      if (handshake) begin
         if (!k_col_last) begin
            k_col_next = k_col_reg + 4'd1;
         end else begin
            k_col_next = 4'd0;
            if (!k_row_last) begin
               k_row_next = k_row_reg + 4'd1;
            end else begin
               k_row_next = 4'd0;
               if (!win_col_last) begin
                  win_col_next = win_col_reg + 4'd1;
               end else begin
                  win_col_next = 4'd0;
                  if (!win_row_last) begin
                     win_row_next = win_row_reg + 4'd1;
                  end else begin
                     win_row_next = 4'd0;
                     quad_next    = quad_reg + 2'd1;
                  end
               end
            end
         end
      end
   end

   // Coordinates are computed from the next indices, so the registered
   // outputs always match the indices that hold them.
   always_comb begin
      row_next = (quad_next[1] ? Q_DIM : 4'd0) + win_row_next + k_row_next;
      col_next = (quad_next[0] ? Q_DIM : 4'd0) + win_col_next + k_col_next;
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (start) state_next = S_LOAD;
         S_LOAD:   state_next = S_STREAM;
         S_STREAM: if (handshake && pass_last_beat) state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // The registered status outputs are decoded from the next state, so
   // they line up with the state they describe.
   always_comb begin
      busy_next  = (state_next != S_IDLE);
      done_next  = (state_next == S_DONE);
      valid_next = (state_next == S_STREAM);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_reg   <= S_IDLE;
         k_col_reg   <= 4'd0;
         k_row_reg   <= 4'd0;
         win_col_reg <= 4'd0;
         win_row_reg <= 4'd0;
         quad_reg    <= 2'd0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         valid_reg   <= 1'b0;
         row_reg     <= 4'd0;
         col_reg     <= 4'd0;
      end else begin
         state_reg   <= state_next;
         k_col_reg   <= k_col_next;
         k_row_reg   <= k_row_next;
         win_col_reg <= win_col_next;
         win_row_reg <= win_row_next;
         quad_reg    <= quad_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         valid_reg   <= valid_next;
         row_reg     <= row_next;
         col_reg     <= col_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign pixel_valid  = valid_reg;
   assign pixel_row    = row_reg;
   assign pixel_col    = col_reg;
   assign quadrant     = quad_reg;
   assign quadrant_lsb = quad_reg[0];

   // The strobes must follow ready in the same cycle, so they are decoded
   // from registered state and the live handshake.
   assign en          = handshake;
   assign new_row     = handshake & k_col_last;
   assign new_vector  = handshake & window_last;

   // The column counter reloads before the first beat, and again as each
   // of the first three quadrants ends. It does not reload at the end of
   // the final quadrant, because no further stream follows.
   assign clear_count = (state_reg == S_LOAD) |
                        (handshake & quad_last_beat & (quad_reg != 2'b11));

`ifdef CONV_SEQ_STALL_COUNT_EN
   // ------------------------------------------------------------------
   // Backpressure monitor. It is zeroed when a pass is accepted, and it
   // keeps its value after done so that the layer controller can read it
   // at any time.
   // ------------------------------------------------------------------
   logic [15:0] stall_reg;

   always_ff @(posedge clock) begin
      if (clear) begin
         stall_reg <= 16'd0;
      end else if ((state_reg == S_IDLE) && start) begin
         stall_reg <= 16'd0;
      end else if (valid_reg && !ready && (stall_reg != 16'hFFFF)) begin
         stall_reg <= stall_reg + 16'd1;
      end
   end

   assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_sequencer
//
// Directed bench for conv_window_sequencer using the default parameters
// (QUAD_DIM=6, KERNEL=3).
//
// Scenarios covered:
//   - reset state
//   - full pass with a stray start at beat 50
//   - ready dropped for 3 cycles on beat 5
//   - abort with clear at beat 100
//   - clean restart after the abort
//   - start and clear asserted together while idle
//
// The expected coordinates at each checkpoint beat are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_conv_window_sequencer;

   logic       clock;
   logic       clear;
   logic       start;
   logic       ready;
   logic       busy;
   logic       done;
   logic       pixel_valid;
   logic [3:0] pixel_row;
   logic [3:0] pixel_col;
   logic [1:0] quadrant;
   logic       quadrant_lsb;
   logic       en;
   logic       new_row;
   logic       new_vector;
   logic       clear_count;
`ifdef CONV_SEQ_STALL_COUNT_EN
   logic [15:0] stall_cycles;
`endif

   int n_cmp = 0;
   int n_err = 0;

   conv_window_sequencer dut (
      .clock        (clock),
      .clear        (clear),
      .start        (start),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .pixel_valid  (pixel_valid),
      .pixel_row    (pixel_row),
      .pixel_col    (pixel_col),
      .quadrant     (quadrant),
      .quadrant_lsb (quadrant_lsb),
      .en           (en),
      .new_row      (new_row),
      .new_vector   (new_vector),
      .clear_count  (clear_count)
`ifdef CONV_SEQ_STALL_COUNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [13:0] mk(input int r, input int c, input int q,
                                      input bit nr, input bit nv, input bit cc);
      logic [1:0] qq;
      qq = 2'(q);
      return {4'(r), 4'(c), qq, qq[0], nr, nv, cc};
   endfunction

   // Checkpoint beats:
   //   {row, col, quadrant, quadrant_lsb, new_row, new_vector, clear_count}
   function automatic bit checkpoint(input int b, output logic [13:0] v);
      bit hit;
      hit = 1'b1;
      v   = 14'd0;
      case (b)
         1:       v = mk(0, 0, 0, 0, 0, 0);
         2:       v = mk(0, 1, 0, 0, 0, 0);
         3:       v = mk(0, 2, 0, 1, 0, 0);
         4:       v = mk(1, 0, 0, 0, 0, 0);
         5:       v = mk(1, 1, 0, 0, 0, 0);
         6:       v = mk(1, 2, 0, 1, 0, 0);
         7:       v = mk(2, 0, 0, 0, 0, 0);
         8:       v = mk(2, 1, 0, 0, 0, 0);
         9:       v = mk(2, 2, 0, 1, 1, 0);
         10:      v = mk(0, 1, 0, 0, 0, 0);
         144:     v = mk(5, 5, 0, 1, 1, 1);
         145:     v = mk(0, 6, 1, 0, 0, 0);
         288:     v = mk(5, 11, 1, 1, 1, 1);
         289:     v = mk(6, 0, 2, 0, 0, 0);
         432:     v = mk(11, 5, 2, 1, 1, 1);
         576:     v = mk(11, 11, 3, 1, 1, 0);
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   // One pass.
   //   stall_beat / stall_len : hold ready low while that beat is presented
   //   abort_beat             : assert clear on that beat's handshake
   //   dup_start_beat         : pulse start while that beat is presented
   //   exp_done_cyc           : cycle (counted from start) where done pulses
   task automatic run_pass(input string name, input int stall_beat, input int stall_len,
                           input int abort_beat, input int dup_start_beat,
                           input int exp_done_cyc);
      int cyc;
      int beats;
      int stall_left;
      int done_cyc;
      int nrow_cnt;
      int nvec_cnt;
      int cc_cnt;
      bit aborted;
      bit done_seen;
      logic [13:0] exp_vec;

      cyc        = 0;
      beats      = 0;
      stall_left = stall_len;
      done_cyc   = -1;
      nrow_cnt   = 0;
      nvec_cnt   = 0;
      cc_cnt     = 0;
      aborted    = 1'b0;

      start = 1'b1;
      ready = 1'b1;
      tick();
      cyc   = 1;
      start = 1'b0;
      #1;
      check({name, " load_busy"},  32'(busy),        1);
      check({name, " load_cc"},    32'(clear_count), 1);
      check({name, " load_valid"}, 32'(pixel_valid), 0);
`ifdef CONV_SEQ_STALL_COUNT_EN
      check({name, " stall_rst"},  32'(stall_cycles), 0);
`endif

      while (done_cyc < 0 && !aborted && cyc < 2000) begin
         tick();
         cyc++;
         ready = 1'b1;
         start = 1'b0;
         clear = 1'b0;
         if (pixel_valid && (beats + 1 == stall_beat) && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
         end
         if (pixel_valid && (beats + 1 == dup_start_beat)) start = 1'b1;
         if (pixel_valid && (beats + 1 == abort_beat))     clear = 1'b1;
         #1;
         if (cyc == 2) check({name, " first_valid"}, 32'(pixel_valid), 1);
         if (pixel_valid && !ready) begin
            check({name, " stall_hold"},
                  32'({pixel_row, pixel_col, en, new_row, new_vector}),
                  32'({4'd1, 4'd1, 3'b000}));
         end
         if (en) begin
            beats++;
            if (new_row)     nrow_cnt++;
            if (new_vector)  nvec_cnt++;
            if (clear_count) cc_cnt++;
            if (checkpoint(beats, exp_vec)) begin
               check($sformatf("%s beat%0d", name, beats),
                     32'({pixel_row, pixel_col, quadrant, quadrant_lsb,
                          new_row, new_vector, clear_count}),
                     32'(exp_vec));
            end
            if (clear) aborted = 1'b1;
         end
         if (done) begin
            done_cyc = cyc;
            check({name, " done_busy"},  32'(busy),        1);
            check({name, " done_valid"}, 32'(pixel_valid), 0);
         end
      end

      if (aborted) begin
         tick();
         clear = 1'b0;
         #1;
         check({name, " abort_state"},
               32'({busy, pixel_valid, quadrant, done}), 0);
         done_seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (done) done_seen = 1'b1;
         end
         check({name, " abort_no_done"}, 32'(done_seen), 0);
      end else begin
         check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
         check({name, " beats"},      32'(beats),    576);
         check({name, " new_rows"},   32'(nrow_cnt), 192);
         check({name, " new_vecs"},   32'(nvec_cnt), 64);
         check({name, " quad_cc"},    32'(cc_cnt),   3);
`ifdef CONV_SEQ_STALL_COUNT_EN
         check({name, " stall_cnt"},  32'(stall_cycles), 32'(stall_len));
`endif
         tick();
         #1;
         check({name, " after_done"}, 32'({busy, done}), 0);
      end
   endtask

   initial begin
      clear = 1'b1;
      start = 1'b0;
      ready = 1'b1;
      tick();
      tick();
      tick();
      #1;
      check("reset_state",
            32'({busy, done, pixel_valid, pixel_row, pixel_col, quadrant,
                 quadrant_lsb, en, new_row, new_vector, clear_count}), 0);
      clear = 1'b0;
      tick();

      run_pass("pass_a",  0, 0,   0, 50, 578);
      run_pass("stall",   5, 3,   0,  0, 581);
      run_pass("abort",   0, 0, 100,  0,   0);
      run_pass("restart", 0, 0,   0,  0, 578);

      // Start and clear asserted together in idle: clear wins.
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      #1;
      check("start_clear_busy", 32'(busy), 0);
      tick();
      #1;
      check("start_clear_idle", 32'({busy, pixel_valid, clear_count}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
